// File: rtl/seg_pkg.sv
// Shared segment character codes, FSM encoding and source-priority helpers
// for the segment message scheduler.
package seg_pkg;

  localparam int         N_SRC      = 3;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_SHOW_TIMED   = 2'd1;
  localparam logic [1:0] ST_SHOW_PERSIST = 2'd2;

  typedef logic [7:0] seg_char_t;

  // Active-high segment codes, bit order {dp,g,f,e,d,c,b,a}
  localparam seg_char_t CHAR_0     = 8'h3F;
  localparam seg_char_t CHAR_1     = 8'h06;
  localparam seg_char_t CHAR_2     = 8'h5B;
  localparam seg_char_t CHAR_3     = 8'h4F;
  localparam seg_char_t CHAR_4     = 8'h66;
  localparam seg_char_t CHAR_5     = 8'h6D;
  localparam seg_char_t CHAR_6     = 8'h7D;
  localparam seg_char_t CHAR_7     = 8'h07;
  localparam seg_char_t CHAR_8     = 8'h7F;
  localparam seg_char_t CHAR_9     = 8'h6F;
  localparam seg_char_t CHAR_A     = 8'h77;
  localparam seg_char_t CHAR_B     = 8'h7C;
  localparam seg_char_t CHAR_C     = 8'h39;
  localparam seg_char_t CHAR_D     = 8'h5E;
  localparam seg_char_t CHAR_E     = 8'h79;
  localparam seg_char_t CHAR_F     = 8'h71;
  localparam seg_char_t CHAR_R     = 8'h50;
  localparam seg_char_t CHAR_N     = 8'h54;
  localparam seg_char_t CHAR_P     = 8'h73;
  localparam seg_char_t CHAR_U     = 8'h3E;
  localparam seg_char_t CHAR_T     = 8'h78;
  localparam seg_char_t CHAR_Y     = 8'h6E;
  localparam seg_char_t CHAR_J     = 8'h1E;
  localparam seg_char_t CHAR_MINUS = 8'h40;
  localparam seg_char_t CHAR_BLANK = 8'h00;

  // Lowest set index wins (source 0 is highest priority)
  function automatic logic [1:0] lowest_set(input logic [N_SRC-1:0] v);
    logic [1:0] r;
    r = OWNER_NONE;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [N_SRC-1:0] owner_onehot(input logic [1:0] own);
    logic [N_SRC-1:0] r;
    case (own)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_msg_scheduler_if.sv
// Request/response bundle between display sources and the message scheduler.
interface seg_msg_scheduler_if;
  import seg_pkg::*;

  logic [N_SRC-1:0]    req_valid;
  logic [64*N_SRC-1:0] req_msg;
  logic [4*N_SRC-1:0]  req_secs;
  logic [N_SRC-1:0]    req_ack;
  logic [N_SRC-1:0]    req_done;
  logic [63:0]         frame;
  logic [1:0]          owner;
  logic [3:0]          time_left;

  modport slave (
    input  req_valid, req_msg, req_secs,
    output req_ack, req_done, frame, owner, time_left
  );

  modport master (
    output req_valid, req_msg, req_secs,
    input  req_ack, req_done, frame, owner, time_left
  );

endinterface

// File: rtl/seg_tick_gen.sv
// One-second tick generator; the count runs one cycle ahead of the cycle it
// describes so the scheduler's registered frame lines up with second_half.
module seg_tick_gen #(
  parameter int DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic second_half
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr)                       cnt_d = CW'(1);
    else if (cnt_q == CW'(DIV-1))  cnt_d = '0;
    else                           cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick        = (cnt_q == '0);
  assign second_half = (cnt_q >= CW'(DIV/2));

endmodule

// File: rtl/seg_msg_scheduler.sv
// Priority scheduler that grants one of three sources the 8-digit display.
// state            | meaning
// ST_IDLE          | no owner, blank frame, grant lowest requesting index
// ST_SHOW_TIMED    | frozen message, counts down seconds, blinks last half-second
// ST_SHOW_PERSIST  | live message from owner until it drops req_valid
module seg_msg_scheduler
  import seg_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic                clk,
  input  logic                rst,
  seg_msg_scheduler_if.slave  bus
);

  logic [1:0]       state_q, state_d;
  logic [63:0]      frame_q, frame_d;
  logic [63:0]      msg_q, msg_d;
  logic [1:0]       owner_q, owner_d;
  logic [3:0]       tl_q, tl_d;
  logic [N_SRC-1:0] ack_q, ack_d;
  logic [N_SRC-1:0] done_q, done_d;

  logic [N_SRC-1:0] prio_mask;
  logic [1:0]       cand;
  logic             grant;
  logic [63:0]      cand_msg, own_msg;
  logic [3:0]       cand_secs, tl_next;
  logic             own_valid;
  logic             tick, second_half;

  seg_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk         (clk),
    .rst         (rst),
    .clr         (grant),
    .tick        (tick),
    .second_half (second_half)
  );

  // Only strictly higher-priority sources may take over a shown message
  always_comb begin
    case (owner_q)
      2'd0:    prio_mask = 3'b000;
      2'd1:    prio_mask = 3'b001;
      2'd2:    prio_mask = 3'b011;
      default: prio_mask = 3'b111;
    endcase
  end

  assign cand      = lowest_set(bus.req_valid & prio_mask);
  assign grant     = (cand != OWNER_NONE);
  assign own_valid = |(bus.req_valid & owner_onehot(owner_q));

  always_comb begin
    case (cand)
      2'd0:    begin cand_msg = bus.req_msg[63:0];    cand_secs = bus.req_secs[3:0];  end
      2'd1:    begin cand_msg = bus.req_msg[127:64];  cand_secs = bus.req_secs[7:4];  end
      2'd2:    begin cand_msg = bus.req_msg[191:128]; cand_secs = bus.req_secs[11:8]; end
      default: begin cand_msg = '0;                   cand_secs = '0;                 end
    endcase
  end

  always_comb begin
    case (owner_q)
      2'd0:    own_msg = bus.req_msg[63:0];
      2'd1:    own_msg = bus.req_msg[127:64];
      2'd2:    own_msg = bus.req_msg[191:128];
      default: own_msg = '0;
    endcase
  end

  assign tl_next = tick ? (tl_q - 4'd1) : tl_q;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    msg_d   = msg_q;
    owner_d = owner_q;
    tl_d    = tl_q;
    ack_d   = '0;
    done_d  = '0;
    if (grant) begin
      state_d = (cand_secs != 4'd0) ? ST_SHOW_TIMED : ST_SHOW_PERSIST;
      frame_d = cand_msg;
      msg_d   = cand_msg;
      owner_d = cand;
      tl_d    = cand_secs;
      ack_d   = owner_onehot(cand);
    end else begin
      case (state_q)
        ST_SHOW_PERSIST: begin
          if (!own_valid) begin
            state_d = ST_IDLE;
            frame_d = '0;
            owner_d = OWNER_NONE;
            tl_d    = '0;
          end else begin
            frame_d = own_msg;
          end
        end
        ST_SHOW_TIMED: begin
          if (tick && tl_q == 4'd1) begin
            done_d  = owner_onehot(owner_q);
            state_d = ST_IDLE;
            frame_d = '0;
            owner_d = OWNER_NONE;
            tl_d    = '0;
          end else begin
            tl_d    = tl_next;
            frame_d = (tl_next == 4'd1 && second_half) ? '0 : msg_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          frame_d = '0;
          owner_d = OWNER_NONE;
          tl_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      msg_q   <= '0;
      owner_q <= OWNER_NONE;
      tl_q    <= '0;
      ack_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      msg_q   <= msg_d;
      owner_q <= owner_d;
      tl_q    <= tl_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign bus.frame     = frame_q;
  assign bus.owner     = owner_q;
  assign bus.time_left = tl_q;
  assign bus.req_ack   = ack_q;
  assign bus.req_done  = done_q;

endmodule

// File: doc/seg_msg_scheduler.md
SEG_MSG_SCHEDULER -- requirements
Module: seg_msg_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000_000: clk cycles per 1 s tick.
REQ-002 SHALL have port clk, input, 1: single clock; the only clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 3: per-source display request; source 0 highest priority (error), 1 bonus, 2 mode banner.
REQ-005 SHALL have port req_msg, input, 192: source i at [64i+63:64i]; byte 7 (MSB) = leftmost digit; active-high segment codes {dp,g..a}.
REQ-006 SHALL have port req_secs, input, 12: source i duration at [4i+3:4i]; 0 = persistent, 1..15 = timed seconds.
REQ-007 SHALL have port req_ack, output, 3: one-cycle pulse to the granted source.
REQ-008 SHALL have port req_done, output, 3: one-cycle pulse when the source's timed message expires.
REQ-009 SHALL have port frame, output, 64: registered segment codes for the scan driver.
REQ-010 SHALL have port owner, output, 2: current owner index; 3 = none.
REQ-011 SHALL have port time_left, output, 4: remaining seconds of a timed message; 0 otherwise.

Function
REQ-012 SHALL implement FSM IDLE, SHOW_TIMED, SHOW_PERSIST; frame = 0 in IDLE.
REQ-013 IDLE: if any req_valid, SHALL grant the lowest index at the next edge: latch msg into frame, set owner, pulse req_ack, latch req_secs; state = SHOW_TIMED if secs != 0, else SHOW_PERSIST.
REQ-014 Latency SHALL be one cycle: req_valid sampled at edge N; frame, owner, and req_ack valid after edge N.
REQ-015 SHOW_PERSIST: frame SHALL reload the owner's req_msg every cycle (live values, e.g. countdown digits).
REQ-016 SHOW_PERSIST: owner req_valid low SHALL return to IDLE at the next edge, with frame = 0 and owner = 3.
REQ-017 SHOW_TIMED: req_valid of the owner and of lower-priority sources SHALL be ignored; frame SHALL stay frozen at the latched message.
REQ-018 Tick counter SHALL clear on every grant, so the first second is a full TICK_DIV cycles.
REQ-019 time_left SHALL load secs on grant and decrement on each tick.
REQ-020 When time_left = 1 and a tick occurs, SHALL pulse req_done[owner] and enter IDLE.
REQ-021 While time_left = 1, frame SHALL read 0 when tick count >= TICK_DIV/2 (last-second blink).
REQ-022 In either SHOW state, req_valid from a higher-priority source SHALL preempt at the next edge, as a fresh grant per REQ-013; no req_done for the preempted source.
REQ-023 Expiry tick and higher-priority request in the same cycle: preemption SHALL win; no req_done.
REQ-024 A timed requester SHALL drop req_valid in the req_ack cycle; if still high on return to IDLE, it is re-granted (defined behaviour, not an error).
REQ-025 At most one bit of req_ack | req_done SHALL be high per cycle.
REQ-026 All outputs SHALL be registered; no combinational path from req_* to frame.

Reset
REQ-027 rst high SHALL immediately set state IDLE, frame 0, owner 3, time_left 0, req_ack 0, req_done 0, tick counter 0, including mid-message; no done pulse on release.

Structure
REQ-028 Shared package seg_pkg SHALL hold segment character codes (CHAR_0..F, E, r, n, P, U, t, y, J, MINUS, BLANK), FSM encoding, N_SRC = 3, OWNER_NONE = 2'd3.
REQ-029 Sub-module seg_tick_gen SHALL provide parameter DIV, input clr, and outputs tick (pulse) and second_half (count >= DIV/2).

Verification (TICK_DIV = 10)
REQ-030 req_valid = 3'b100, secs2 = 0, msg2 = "InPut 05" -> ack[2] after 1 edge; frame = msg2; owner = 2; drop valid -> frame 0, owner 3 next edge.
REQ-031 Source 1 timed, secs = 3 -> time_left 3,2,1 at 10-cycle spacing; blinks cycles 25-29; done[1] at cycle 30; IDLE.
REQ-032 Source 2 persistent active; source 0 asserts "Err 5" secs 0 -> owner 0 next edge; source 0 drops -> IDLE, then source 2 re-granted one cycle later.
REQ-033 Source 1 timed, secs = 1, with source 0 asserting on the expiry-tick cycle -> owner 0; no done[1].
REQ-034 Persistent source 0 updates msg every cycle -> frame follows with 1-cycle delay.
REQ-035 rst pulsed mid timed message, time_left = 2 -> frame 0, owner 3, no done; identical regrant after release.
